sam_mem_interface: RTL
======================

// Module: sam_mem_interface
// PURPOSE
//  Multi-cycle memory port for the SAM CPU, directly upstream of the microprogrammed controller.
//  Takes the memory-read/write strobes from the controller's bus_controller word, plus the MAR
//  address and the datapath write data. Runs a timed access against an internal RAM.
//  Generates the active-low wait_ that the controller's alpha/beta mux samples to stall its
//  microsequence. Read data is returned in a register for MBR load.
// PARAMETERS
//  ADDR_W       12    address width (MAR width)
//  DATA_W       16    word width
//  WAIT_CYCLES  2     access latency in BUSY cycles; legal range 1..15, 0 is illegal
//  MEM_DEPTH    4096  RAM words; must equal 2**ADDR_W
// PORTS
//  clk        in   1       single clock, all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  rd_req     in   1       memory-read strobe (bit of bus_controller), level, held until wait_=1
//  wr_req     in   1       memory-write strobe (bit of bus_controller), level, held until wait_=1
//  addr       in   ADDR_W  MAR value, sampled on accept
//  wdata      in   DATA_W  write data, sampled on accept
//  wait_      out  1       0 = access in progress (controller must hold); 1 = idle/complete
//  rdata      out  DATA_W  registered read data, stable from DONE until next read completes
//  rdata_vld  out  1       1-cycle pulse in DONE after a read
//  req_err    out  1       sticky: rd_req & wr_req seen together on accept
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, rdata=0, rdata_vld=0, req_err=0, wait_=1.
//   RAM contents are not reset.
//  FSM states: IDLE, BUSY, DONE.
//   - IDLE:
//       . With req=rd_req|wr_req on a posedge: latch addr, wdata and op (write wins if both;
//         both also sets req_err). cnt<=WAIT_CYCLES-1; go to BUSY.
//       . With no request: stay in IDLE.
//   - BUSY:
//       . cnt>0: cnt<=cnt-1.
//       . cnt==0 posedge: perform the access; go to DONE.
//           write: RAM[addr_q]<=wdata_q.
//           read: rdata<=RAM[addr_q] and rdata_vld<=1.
//   - DONE: lasts 1 cycle and always returns to IDLE. rdata_vld falls on exit.
//       A request still asserted in DONE is ignored; it is accepted in the next IDLE cycle.
//  wait_ is combinational: wait_ = ~((state==IDLE & (rd_req|wr_req)) | state==BUSY).
//   - No combinational path from wait_ back to the request inputs; the strobes derive from the
//     controller state register only.
//  Latency: request seen in cycle 0 -> wait_=0 for WAIT_CYCLES+1 cycles -> DONE (wait_=1) in
//   cycle WAIT_CYCLES+1. The controller advances on the edge closing DONE.
//  Request deasserted mid-BUSY: the access still completes; the latched op, addr and data are used.
//  addr/wdata changes after accept have no effect.
//  Reset mid-BUSY: abort immediately with no RAM write; a pending read leaves rdata=0.
//  Back-to-back ops: minimum spacing is WAIT_CYCLES+2 cycles (IDLE, BUSY x W, DONE).
//  addr wraps naturally within MEM_DEPTH; no out-of-range state exists.
// STRUCTURE
//  sam_pkg (shared):
//   - FSM state typedef: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
//   - localparams for the bus_controller bit indices of RD and WR.
//   - default ADDR_W and DATA_W.
//  Sub-module sam_ram: synchronous-write, synchronous-read single-port RAM (DATA_W x MEM_DEPTH)
//   with a preload hook for the bench. The interface owns all timing; the RAM has no reset.
// TESTING
//  1 Reset: hold rst_n=0 with rd_req=1 -> wait_=1, rdata=0, rdata_vld=0, req_err=0, state IDLE.
//  2 Write then read, W=2: wr_req, addr=12'h0A5, wdata=16'hBEEF ->
//     wait_=0 for 3 cycles, then 1 for one cycle.
//    Then rd_req at 12'h0A5 -> rdata=16'hBEEF with rdata_vld pulse in the DONE cycle.
//  3 Reset mid-BUSY: wr_req at 12'h010 (preloaded 16'h1234) with rst_n pulsed low in BUSY ->
//     a following read returns 16'h1234 and wait_=1 right after reset.
//  4 Both strobes: rd_req=wr_req=1, addr=12'h001, wdata=16'h00FF -> write performed,
//     req_err=1 and it stays 1 until reset.
//  5 Held request: rd_req held high through DONE ->
//     second access starts in the following IDLE cycle.
//    Also change addr during BUSY -> the original address is used.
//  6 Latency sweep W=1,4,15 -> wait_ low exactly W+1 cycles per access; wrap at addr=12'hFFF is OK.

Source files
------------

// File: rtl/sam_pkg.sv
// Shared definitions for the SAM memory port: FSM encoding, bus_controller
// bit positions of the memory strobes and default bus widths.
package sam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sam_state_t;

  // Positions of the memory strobes inside the controller's bus_controller word
  localparam int BC_RD_BIT = 0;
  localparam int BC_WR_BIT = 1;

  localparam int SAM_ADDR_W = 12;
  localparam int SAM_DATA_W = 16;

endpackage

// File: rtl/sam_ram.sv
// Single-port RAM with synchronous write and registered (read-first) read.
// No reset; contents persist across interface resets. The mem array is the
// preload hook: a bench may deposit words into it hierarchically.
module sam_ram #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Write when enabled; read port always registers the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sam_mem_interface.sv
// Multi-cycle memory port for the SAM CPU. Accepts a read/write strobe in
// IDLE, spends WAIT_CYCLES cycles in BUSY, performs the access on the last
// BUSY edge and shows a one-cycle DONE. wait_ stalls the microsequencer.
module sam_mem_interface
  import sam_pkg::*;
#(
  parameter int ADDR_W      = SAM_ADDR_W,
  parameter int DATA_W      = SAM_DATA_W,
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_DEPTH   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wait_,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic              req_err
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  sam_state_t        state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic              op_wr_reg;
  logic [ADDR_W-1:0] addr_q_reg;
  logic [DATA_W-1:0] wdata_q_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              rdata_vld_reg;
  logic              req_err_reg;

  logic              req;
  logic              access;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;

  assign req    = rd_req | wr_req;
  assign access = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign ram_we = access & op_wr_reg;
  // While idle the RAM is pointed at the live MAR so the read word is already
  // registered after the accept edge; this keeps WAIT_CYCLES=1 reads correct.
  assign ram_addr = (state_reg == IDLE) ? addr : addr_q_reg;

  sam_ram #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q_reg),
    .rdata (ram_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the combinational stall output (forced idle in reset)
  always_comb begin
    state_next = state_reg;
    wait_      = ~(rst_n & (((state_reg == IDLE) & req) | (state_reg == BUSY)));
    case (state_reg)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    if (cnt_reg == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, latency counter, read-data register and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= 4'd0;
      op_wr_reg     <= 1'b0;
      addr_q_reg    <= '0;
      wdata_q_reg   <= '0;
      rdata_reg     <= '0;
      rdata_vld_reg <= 1'b0;
      req_err_reg   <= 1'b0;
    end else begin
      rdata_vld_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_q_reg  <= addr;
            wdata_q_reg <= wdata;
            op_wr_reg   <= wr_req;
            cnt_reg     <= CNT_INIT;
            if (rd_req && wr_req) begin
              req_err_reg <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else if (!op_wr_reg) begin
            rdata_reg     <= ram_q;
            rdata_vld_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata     = rdata_reg;
  assign rdata_vld = rdata_vld_reg;
  assign req_err   = req_err_reg;

endmodule
